ctrl_unit: RTL and testbench

CTRL_UNIT -- requirements
Module: ctrl_unit

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/ctrl_decode.sv | 58 +++++
 rtl/ctrl_unit.sv | 132 +++++++++++++
 tb/tb_ctrl_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the tiny CPU control path: opcodes, ALU (mode, select)
// encodings, FSM state encoding and jump-condition kinds.
// No ports; imported by ctrl_decode and ctrl_unit.
package cpu_pkg;

   // Opcodes (instr[7:4])
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_NOT = 4'h3;
   localparam logic [3:0] OP_MOV = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JC  = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_NOP = 4'hF;

   // ALU mode: 1 = arithmetic/logic on (rd, rs), 0 = pass-through of rs
   localparam logic       ALU_M_OP   = 1'b1;
   localparam logic       ALU_M_PASS = 1'b0;

   // ALU select codes
   localparam logic [3:0] ALU_S_ADD  = 4'b1001;
   localparam logic [3:0] ALU_S_SUB  = 4'b0110;
   localparam logic [3:0] ALU_S_AND  = 4'b1011;
   localparam logic [3:0] ALU_S_NOT  = 4'b0101;
   localparam logic [3:0] ALU_S_PASS = 4'b1100;
   localparam logic [3:0] ALU_S_IDLE = 4'b0000;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      JC_NEVER  = 2'd0,
      JC_ALWAYS = 2'd1,
      JC_CARRY  = 2'd2,
      JC_ZERO   = 2'd3
   } jump_cond_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> ALU controls and instruction class.
// Ports: opcode_i in; alu_m_o/alu_s_o ALU controls; writes_reg_o, sets_flags_o,
//        is_jump_o, jump_cond_o, illegal_o instruction class outputs.
module ctrl_decode
   import cpu_pkg::*;
(
   input  logic [3:0] opcode_i,
   output logic       alu_m_o,
   output logic [3:0] alu_s_o,
   output logic       writes_reg_o,
   output logic       sets_flags_o,
   output logic       is_jump_o,
   output jump_cond_e jump_cond_o,
   output logic       illegal_o
);

   always_comb begin
      alu_m_o      = ALU_M_PASS;
      alu_s_o      = ALU_S_IDLE;
      writes_reg_o = 1'b0;
      sets_flags_o = 1'b0;
      is_jump_o    = 1'b0;
      jump_cond_o  = JC_NEVER;
      illegal_o    = 1'b0;
      case (opcode_i)
         OP_ADD: begin
            alu_m_o = ALU_M_OP; alu_s_o = ALU_S_ADD;
            writes_reg_o = 1'b1; sets_flags_o = 1'b1;
         end
         OP_SUB: begin
            alu_m_o = ALU_M_OP; alu_s_o = ALU_S_SUB;
            writes_reg_o = 1'b1; sets_flags_o = 1'b1;
         end
         OP_AND: begin
            alu_m_o = ALU_M_OP; alu_s_o = ALU_S_AND; writes_reg_o = 1'b1;
         end
         OP_NOT: begin
            alu_m_o = ALU_M_OP; alu_s_o = ALU_S_NOT; writes_reg_o = 1'b1;
         end
         OP_MOV: begin
            alu_s_o = ALU_S_PASS; writes_reg_o = 1'b1;
         end
         // Jumps route rs through the ALU so the target appears on its result
         OP_JMP: begin
            alu_s_o = ALU_S_PASS; is_jump_o = 1'b1; jump_cond_o = JC_ALWAYS;
         end
         OP_JC: begin
            alu_s_o = ALU_S_PASS; is_jump_o = 1'b1; jump_cond_o = JC_CARRY;
         end
         OP_JZ: begin
            alu_s_o = ALU_S_PASS; is_jump_o = 1'b1; jump_cond_o = JC_ZERO;
         end
         OP_NOP: ;
         default: illegal_o = 1'b1;  // 1000-1110: run as NOP, flag it
      endcase
   end

endmodule

// File: rtl/ctrl_unit.sv
// Control unit: FETCH->DECODE->EXEC->WB sequencer with IR, carry/zero flags and
// sticky illegal-opcode flag. Ports: clk/rst; instr/instr_valid/instr_ready
// handshake; alu_cf/alu_zf in; ALU, register-file, PC and status outputs.
module ctrl_unit
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic       alu_cf,
   input  logic       alu_zf,
   output logic       alu_m,
   output logic [3:0] alu_s,
   output logic [1:0] a_sel,
   output logic [1:0] b_sel,
   output logic [1:0] wr_sel,
   output logic       reg_we,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       cf_q,
   output logic       zf_q,
   output logic       illegal
);

   state_e     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic       cf_d, zf_d;
   logic       illegal_q, illegal_d;

   logic       dec_alu_m;
   logic [3:0] dec_alu_s;
   logic       dec_writes_reg, dec_sets_flags, dec_is_jump, dec_illegal;
   jump_cond_e dec_jump_cond;
   logic       jump_taken;

   ctrl_decode u_decode (
      .opcode_i     (ir_q[7:4]),
      .alu_m_o      (dec_alu_m),
      .alu_s_o      (dec_alu_s),
      .writes_reg_o (dec_writes_reg),
      .sets_flags_o (dec_sets_flags),
      .is_jump_o    (dec_is_jump),
      .jump_cond_o  (dec_jump_cond),
      .illegal_o    (dec_illegal)
   );

   // Condition is evaluated on the stored flags, so a jump right after
   // ADD/SUB sees the flags that instruction captured at the end of EXEC.
   always_comb begin
      case (dec_jump_cond)
         JC_ALWAYS: jump_taken = 1'b1;
         JC_CARRY:  jump_taken = cf_q;
         JC_ZERO:   jump_taken = zf_q;
         default:   jump_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      cf_d        = cf_q;
      zf_d        = zf_q;
      illegal_d   = illegal_q;
      instr_ready = 1'b0;
      pc_inc      = 1'b0;
      alu_m       = ALU_M_PASS;
      alu_s       = ALU_S_IDLE;
      a_sel       = 2'b00;
      b_sel       = 2'b00;
      wr_sel      = 2'b00;
      reg_we      = 1'b0;
      pc_load     = 1'b0;

      if (state_q != ST_FETCH) begin
         alu_m  = dec_alu_m;
         alu_s  = dec_alu_s;
         a_sel  = ir_q[1:0];
         b_sel  = ir_q[3:2];
         wr_sel = ir_q[3:2];
      end

      case (state_q)
         ST_FETCH: begin
            // rst gating keeps the handshake quiet while reset is held
            instr_ready = ~rst;
            if (instr_valid && !rst) begin
               ir_d    = instr;
               pc_inc  = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_illegal) illegal_d = 1'b1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (dec_sets_flags) begin
               cf_d = alu_cf;
               zf_d = alu_zf;
            end
            state_d = ST_WB;
         end
         ST_WB: begin
            reg_we  = dec_writes_reg;
            pc_load = dec_is_jump & jump_taken;
            state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         ir_q      <= 8'h00;
         cf_q      <= 1'b0;
         zf_q      <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         cf_q      <= cf_d;
         zf_q      <= zf_d;
         illegal_q <= illegal_d;
      end
   end

   assign illegal = illegal_q;

endmodule

// File: tb/tb_ctrl_unit.sv
module tb_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic       alu_cf, alu_zf;
   logic       alu_m;
   logic [3:0] alu_s;
   logic [1:0] a_sel, b_sel, wr_sel;
   logic       reg_we, pc_inc, pc_load, cf_q, zf_q, illegal;

   int tests_run = 0;
   int failed    = 0;

   always #5 clk = ~clk;

   ctrl_unit dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_cf(alu_cf), .alu_zf(alu_zf),
      .alu_m(alu_m), .alu_s(alu_s), .a_sel(a_sel), .b_sel(b_sel),
      .wr_sel(wr_sel), .reg_we(reg_we), .pc_inc(pc_inc), .pc_load(pc_load),
      .cf_q(cf_q), .zf_q(zf_q), .illegal(illegal)
   );

   typedef struct packed {
      logic       rdy;
      logic       pc_inc;
      logic       alu_m;
      logic [3:0] alu_s;
      logic [1:0] a_sel;
      logic [1:0] b_sel;
      logic [1:0] wr_sel;
      logic       reg_we;
      logic       pc_load;
      logic       cf_q;
      logic       zf_q;
      logic       illegal;
   } obs_t;

   // phase 0 = acceptance cycle, 1..3 = DECODE/EXEC/WB, 4 = next FETCH
   obs_t obs  [5];
   obs_t expv [5];
   obs_t msk  [5];

   // reference architectural state
   bit m_cf, m_zf, m_ill;

   function automatic obs_t sample();
      obs_t o;
      o.rdy = instr_ready; o.pc_inc = pc_inc; o.alu_m = alu_m; o.alu_s = alu_s;
      o.a_sel = a_sel; o.b_sel = b_sel; o.wr_sel = wr_sel; o.reg_we = reg_we;
      o.pc_load = pc_load; o.cf_q = cf_q; o.zf_q = zf_q; o.illegal = illegal;
      return o;
   endfunction

   // Instruction-level model: what each phase should look like, from the
   // opcode table and the architectural flag rules.
   task automatic model_instr(input logic [7:0] ins, input bit ecf, input bit ezf);
      int   op;
      bit   known, m, wr, take, sets, bad;
      logic [3:0] s;
      bit   ncf, nzf, nill;
      op = int'(ins[7:4]);
      known = 1; m = 0; s = 4'b1100;
      case (op)
         0: begin m = 1; s = 4'b1001; end
         1: begin m = 1; s = 4'b0110; end
         2: begin m = 1; s = 4'b1011; end
         3: begin m = 1; s = 4'b0101; end
         4, 5, 6, 7: begin m = 0; s = 4'b1100; end
         default: known = 0;
      endcase
      wr   = (op <= 4);
      sets = (op <= 1);
      bad  = (op >= 8 && op <= 14);
      take = (op == 5) || (op == 6 && m_cf) || (op == 7 && m_zf);
      ncf  = sets ? ecf : m_cf;
      nzf  = sets ? ezf : m_zf;
      nill = m_ill | bad;
      for (int p = 0; p < 5; p++) begin
         expv[p] = '0;
         msk[p]  = '1;
         expv[p].cf_q    = (p >= 3) ? ncf : m_cf;
         expv[p].zf_q    = (p >= 3) ? nzf : m_zf;
         expv[p].illegal = (p == 4) ? nill : m_ill;
         if (p == 0 || p == 4) expv[p].rdy = 1'b1;
         if (p == 0) expv[p].pc_inc = 1'b1;
         if (p >= 1 && p <= 3) begin
            expv[p].alu_m  = m;
            expv[p].alu_s  = s;
            expv[p].a_sel  = ins[1:0];
            expv[p].b_sel  = ins[3:2];
            expv[p].wr_sel = ins[3:2];
            if (!known) begin msk[p].alu_m = 1'b0; msk[p].alu_s = 4'b0; end
            msk[p].illegal = 1'b0;   // moment of setting inside the instruction is free
         end
         if (p == 3) begin
            expv[p].reg_we  = wr;
            expv[p].pc_load = take;
         end
      end
      m_cf = ncf; m_zf = nzf; m_ill = nill;
   endtask

   // Drive one instruction from a FETCH negedge; returns at the next FETCH.
   task automatic exec_instr(input logic [7:0] ins, input bit ecf, input bit ezf);
      instr = ins; instr_valid = 1'b1;
      alu_cf = 1'($urandom); alu_zf = 1'($urandom);
      #1 obs[0] = sample();
      @(negedge clk);
      instr_valid = 1'b0; instr = 8'($urandom);
      #1 obs[1] = sample();
      @(negedge clk);
      alu_cf = ecf; alu_zf = ezf; instr = 8'($urandom);
      #1 obs[2] = sample();
      @(negedge clk);
      alu_cf = 1'($urandom); alu_zf = 1'($urandom); instr = 8'($urandom);
      #1 obs[3] = sample();
      @(negedge clk);
      #1 obs[4] = sample();
   endtask

   task automatic do_instr(input logic [7:0] ins, input bit ecf, input bit ezf);
      model_instr(ins, ecf, ezf);
      exec_instr(ins, ecf, ezf);
   endtask

   task automatic test_reset();
      rst = 1'b1; instr = 8'hA5; instr_valid = 1'b1; alu_cf = 1'b1; alu_zf = 1'b1;
      m_cf = 0; m_zf = 0; m_ill = 0;
      @(negedge clk);
      #1;
      tests_run++;
      if ({instr_ready, pc_inc, reg_we, pc_load, alu_m, alu_s, cf_q, zf_q, illegal} !== 12'h000) begin
         failed++;
         $display("FAIL reset_outputs: got rdy=%b inc=%b we=%b ld=%b m=%b s=%b cf=%b zf=%b ill=%b, want all 0",
                  instr_ready, pc_inc, reg_we, pc_load, alu_m, alu_s, cf_q, zf_q, illegal);
      end
      @(negedge clk);
      rst = 1'b0; instr_valid = 1'b0;
      #1;
      tests_run++;
      if (instr_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_release_ready: got %b want 1", instr_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_add();
      do_instr(8'h06, 1'b0, 1'b0);
      tests_run++;
      if (obs[0].rdy !== 1'b1 || obs[0].pc_inc !== 1'b1 || obs[1].rdy !== 1'b0) begin
         failed++;
         $display("FAIL add_handshake: rdy0=%b inc0=%b rdy1=%b want 1 1 0", obs[0].rdy, obs[0].pc_inc, obs[1].rdy);
      end
      for (int p = 1; p <= 3; p++) begin
         tests_run++;
         if (obs[p].alu_m !== 1'b1 || obs[p].alu_s !== 4'b1001 || obs[p].reg_we !== (p == 3)) begin
            failed++;
            $display("FAIL add_phase%0d: m=%b s=%b we=%b want 1 1001 %0d", p, obs[p].alu_m, obs[p].alu_s, obs[p].reg_we, p == 3);
         end
      end
      tests_run++;
      if (obs[3].wr_sel !== 2'b01 || obs[4].rdy !== 1'b1 || obs[4].reg_we !== 1'b0 || obs[2].rdy !== 1'b0 || obs[3].rdy !== 1'b0) begin
         failed++;
         $display("FAIL add_wb_latency: wr_sel=%b rdy=%b%b%b we4=%b want 01 0,0,1 0", obs[3].wr_sel, obs[2].rdy, obs[3].rdy, obs[4].rdy, obs[4].reg_we);
      end
   endtask

   task automatic test_sub_jz();
      do_instr(8'h16, 1'b0, 1'b1);
      tests_run++;
      if (obs[4].zf_q !== 1'b1 || obs[4].cf_q !== 1'b0) begin
         failed++;
         $display("FAIL sub_flags: zf=%b cf=%b want 1 0", obs[4].zf_q, obs[4].cf_q);
      end
      do_instr(8'h73, 1'b0, 1'b0);
      tests_run++;
      if (obs[3].pc_load !== 1'b1 || obs[3].alu_m !== 1'b0 || obs[3].alu_s !== 4'b1100 ||
          obs[3].a_sel !== 2'b11 || obs[3].reg_we !== 1'b0 || obs[2].pc_load !== 1'b0) begin
         failed++;
         $display("FAIL jz_taken: ld=%b m=%b s=%b a=%b we=%b ld_exec=%b want 1 0 1100 11 0 0",
                  obs[3].pc_load, obs[3].alu_m, obs[3].alu_s, obs[3].a_sel, obs[3].reg_we, obs[2].pc_load);
      end
   endtask

   task automatic test_flag_isolation();
      do_instr(8'h06, 1'b0, 1'b0);
      do_instr(8'h26, 1'b1, 1'b1);
      tests_run++;
      if (obs[4].zf_q !== 1'b0 || obs[4].cf_q !== 1'b0) begin
         failed++;
         $display("FAIL and_keeps_flags: zf=%b cf=%b want 0 0", obs[4].zf_q, obs[4].cf_q);
      end
      do_instr(8'h73, 1'b1, 1'b1);
      tests_run++;
      if (obs[3].pc_load !== 1'b0) begin
         failed++;
         $display("FAIL jz_not_taken: pc_load=%b want 0", obs[3].pc_load);
      end
   endtask

   task automatic test_idle();
      obs_t ref_o, cur;
      instr_valid = 1'b0;
      #1 ref_o = sample();
      tests_run++;
      if (ref_o.rdy !== 1'b1 || ref_o.pc_inc !== 1'b0 || ref_o.alu_s !== 4'b0000 || ref_o.a_sel !== 2'b00) begin
         failed++;
         $display("FAIL idle_start: %h", ref_o);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         instr = 8'($urandom); alu_cf = 1'($urandom); alu_zf = 1'($urandom);
         #1 cur = sample();
         tests_run++;
         if (cur !== ref_o) begin
            failed++;
            $display("FAIL idle_cycle%0d: got %h want %h", c, cur, ref_o);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_illegal();
      do_instr(8'h9C, 1'b1, 1'b1);
      tests_run++;
      if (obs[3].reg_we !== 1'b0 || obs[3].pc_load !== 1'b0 || obs[4].illegal !== 1'b1 ||
          obs[0].illegal !== 1'b0 || obs[4].cf_q !== m_cf || obs[4].zf_q !== m_zf) begin
         failed++;
         $display("FAIL illegal_op: we=%b ld=%b ill=%b->%b cf=%b zf=%b want 0 0 0->1 %b %b",
                  obs[3].reg_we, obs[3].pc_load, obs[0].illegal, obs[4].illegal, obs[4].cf_q, obs[4].zf_q, m_cf, m_zf);
      end
      for (int k = 0; k < 3; k++) begin
         do_instr({1'b0, 3'($urandom), 4'($urandom)}, 1'($urandom), 1'($urandom));
         tests_run++;
         if (obs[4].illegal !== 1'b1) begin
            failed++;
            $display("FAIL illegal_sticky%0d: got %b want 1", k, obs[4].illegal);
         end
      end
   endtask

   task automatic test_reset_mid();
      instr = 8'h06; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);                // EXEC
      alu_cf = 1'b1; alu_zf = 1'b1;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({instr_ready, pc_inc, reg_we, pc_load, alu_m, alu_s, a_sel, wr_sel, cf_q, zf_q, illegal} !== 16'h0000) begin
         failed++;
         $display("FAIL reset_mid: rdy=%b inc=%b we=%b ld=%b m=%b s=%b a=%b w=%b cf=%b zf=%b ill=%b want all 0",
                  instr_ready, pc_inc, reg_we, pc_load, alu_m, alu_s, a_sel, wr_sel, cf_q, zf_q, illegal);
      end
      @(negedge clk);
      rst = 1'b0;
      m_cf = 0; m_zf = 0; m_ill = 0;
      #1;
      tests_run++;
      if (instr_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_mid_ready: got %b want 1", instr_ready);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         tests_run++;
         if (reg_we !== 1'b0 || pc_load !== 1'b0 || instr_ready !== 1'b1 || cf_q !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_after%0d: we=%b ld=%b rdy=%b cf=%b want 0 0 1 0", c, reg_we, pc_load, instr_ready, cf_q);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] ins;
      for (int n = 0; n < 150; n++) begin
         ins = 8'($urandom);
         do_instr(ins, 1'($urandom), 1'($urandom));
         for (int p = 0; p < 5; p++) begin
            tests_run++;
            if ((obs[p] & msk[p]) !== (expv[p] & msk[p])) begin
               failed++;
               $display("FAIL random%0d_ins%h_phase%0d: got %h want %h (mask %h)", n, ins, p, obs[p], expv[p], msk[p]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_jz();
      test_flag_isolation();
      test_idle();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
